// File: rtl/pc_sequencer.sv
// Program-counter / fetch control for the pipelined RSA CPU: owns the PC, run state,
// NZCV flags, branch condition evaluation, flush pulse and a saturating fetch counter.
module pc_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int IMM_WIDTH  = 24,
  parameter int PC_STEP    = 4,
  parameter int IMM_SHIFT  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  flags_pending,
  input  logic [1:0]            branch_op,
  input  logic [3:0]            cond,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic                  flags_write,
  input  logic [3:0]            alu_flags,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  flag_zero,
  output logic                  running,
  output logic                  flush,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  typedef enum logic [1:0] {
    Idle   = 2'd0,
    Run    = 2'd1,
    Halted = 2'd2
  } stateT;

  stateT                 stateReg, stateNext;
  logic [ADDR_WIDTH-1:0] pcReg, pcNext;
  logic [3:0]            flagsReg, flagsNext;
  logic                  flushReg, flushNext;
  logic                  runningReg;
  logic [CNT_WIDTH-1:0]  countReg, countNext, countInc;

  logic [3:0]            effFlags;
  logic                  flagN, flagZ, flagC, flagV;
  logic                  condTrue;
  logic                  isBranch, isCondBranch, isHalt;
  logic [ADDR_WIDTH-1:0] immExt, branchOffset;

  // Writeback flags bypass the register so a branch right behind a flag setter sees them.
  assign effFlags = flags_write ? alu_flags : flagsReg;
  assign {flagN, flagZ, flagC, flagV} = effFlags;

  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'h0: condTrue = flagZ;
      4'h1: condTrue = !flagZ;
      4'h2: condTrue = flagC;
      4'h3: condTrue = !flagC;
      4'h4: condTrue = flagN;
      4'h5: condTrue = !flagN;
      4'h6: condTrue = flagV;
      4'h7: condTrue = !flagV;
      4'h8: condTrue = flagC && !flagZ;
      4'h9: condTrue = !flagC || flagZ;
      4'hA: condTrue = (flagN == flagV);
      4'hB: condTrue = (flagN != flagV);
      4'hC: condTrue = !flagZ && (flagN == flagV);
      4'hD: condTrue = flagZ || (flagN != flagV);
      4'hE: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  assign isBranch     = (branch_op == 2'b10);
  assign isHalt       = (branch_op == 2'b11);
  assign isCondBranch = isBranch && (cond != 4'hE);

  assign immExt       = {{(ADDR_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
  assign branchOffset = immExt << IMM_SHIFT;
  assign countInc     = (countReg == '1) ? countReg : countReg + CNT_WIDTH'(1);

  always_comb begin
    stateNext = stateReg;
    pcNext    = pcReg;
    countNext = countReg;
    flushNext = 1'b0;
    flagsNext = flags_write ? alu_flags : flagsReg;
    case (stateReg)
      Idle: begin
        pcNext = '0;
        if (start) begin
          stateNext = Run;
          countNext = '0;
        end
      end
      Run: begin
        if (stall) begin
          pcNext = pcReg;
        end else if (isCondBranch && flags_pending && !flags_write) begin
          pcNext = pcReg;
        end else if (isHalt) begin
          countNext = countInc;
          stateNext = Halted;
        end else if (isBranch && condTrue) begin
          pcNext    = pcReg + branchOffset;
          flushNext = 1'b1;
          countNext = countInc;
        end else begin
          pcNext    = pcReg + ADDR_WIDTH'(PC_STEP);
          countNext = countInc;
        end
      end
      Halted: begin
        if (start) begin
          stateNext = Run;
          pcNext    = '0;
          countNext = '0;
        end
      end
      default: begin
        stateNext = Idle;
        pcNext    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateReg   <= Idle;
      pcReg      <= '0;
      flagsReg   <= 4'b0000;
      flushReg   <= 1'b0;
      runningReg <= 1'b0;
      countReg   <= '0;
    end else begin
      stateReg   <= stateNext;
      pcReg      <= pcNext;
      flagsReg   <= flagsNext;
      flushReg   <= flushNext;
      runningReg <= (stateNext == Run);
      countReg   <= countNext;
    end
  end

  assign pc          = pcReg;
  assign flag_zero   = flagsReg[2];
  assign running     = runningReg;
  assign flush       = flushReg;
  assign fetch_count = countReg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer; a second instance with a 4-bit counter
// shares the stimulus to exercise fetch-count saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, flagsPending, flagsWrite;
  logic [1:0]  branchOp;
  logic [3:0]  cond, aluFlags;
  logic [23:0] imm;
  logic [31:0] pc, pc4;
  logic        flagZero, running, flush;
  logic        flagZero4, running4, flush4;
  logic [15:0] fetchCount;
  logic [3:0]  fetchCount4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        running;
    int          cnt;
    logic        fz;
  } expT;

  expT sb[$];

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .flags_pending(flagsPending), .branch_op(branchOp), .cond(cond), .imm(imm),
    .flags_write(flagsWrite), .alu_flags(aluFlags), .pc(pc), .flag_zero(flagZero),
    .running(running), .flush(flush), .fetch_count(fetchCount)
  );

  pc_sequencer #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .flags_pending(flagsPending), .branch_op(branchOp), .cond(cond), .imm(imm),
    .flags_write(flagsWrite), .alu_flags(aluFlags), .pc(pc4), .flag_zero(flagZero4),
    .running(running4), .flush(flush4), .fetch_count(fetchCount4)
  );

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] ePc, input logic eFl,
                      input logic eRun, input int eCnt, input logic eFz);
    expT e;
    e.tag = tag; e.pc = ePc; e.flush = eFl; e.running = eRun; e.cnt = eCnt; e.fz = eFz;
    sb.push_back(e);
  endtask

  task automatic drain();
    expT e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      cmp({e.tag, ".pc"}, pc, e.pc);
      cmp({e.tag, ".flush"}, {31'd0, flush}, {31'd0, e.flush});
      cmp({e.tag, ".running"}, {31'd0, running}, {31'd0, e.running});
      cmp({e.tag, ".count"}, {16'd0, fetchCount}, e.cnt);
      cmp({e.tag, ".flagZero"}, {31'd0, flagZero}, {31'd0, e.fz});
      cmp({e.tag, ".count4"}, {28'd0, fetchCount4}, (e.cnt > 15) ? 15 : e.cnt);
      $display("step %-14s pc=%08h flush=%0b run=%0b cnt=%0d cnt4=%0d fz=%0b",
               e.tag, pc, flush, running, fetchCount, fetchCount4, flagZero);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] c, input logic [23:0] im,
                       input logic st, input logic fp, input logic fw,
                       input logic [3:0] af, input logic go);
    branchOp = op; cond = c; imm = im; stall = st;
    flagsPending = fp; flagsWrite = fw; aluFlags = af; start = go;
  endtask

  task automatic seqOp();
    drive(2'b00, 4'h0, 24'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic stepExp(input string tag, input logic [31:0] ePc, input logic eFl,
                         input logic eRun, input int eCnt, input logic eFz);
    push(tag, ePc, eFl, eRun, eCnt, eFz);
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    logic [31:0] pcE;
    int          cntE;

    reset = 1'b1;
    seqOp();
    @(posedge clk);
    #1;
    push("reset", 32'h0, 1'b0, 1'b0, 0, 1'b0);
    drain();
    reset = 1'b0;

    // start, then three sequential fetches
    drive(2'b00, 4'h0, 24'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    stepExp("start", 32'h0, 1'b0, 1'b1, 0, 1'b0);
    seqOp(); stepExp("seq1", 32'h4, 1'b0, 1'b1, 1, 1'b0);
    seqOp(); stepExp("seq2", 32'h8, 1'b0, 1'b1, 2, 1'b0);
    seqOp(); stepExp("seq3", 32'hC, 1'b0, 1'b1, 3, 1'b0);

    // write Z, then BEQ backwards by two words at 0x10
    drive(2'b00, 4'h0, 24'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0);
    stepExp("setZ", 32'h10, 1'b0, 1'b1, 4, 1'b1);
    drive(2'b10, 4'h0, 24'hFFFFFE, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    stepExp("beq", 32'h08, 1'b1, 1'b1, 5, 1'b1);
    seqOp(); stepExp("afterBeq", 32'h0C, 1'b0, 1'b1, 6, 1'b1);

    pcE = 32'h0C; cntE = 6;
    for (int i = 0; i < 5; i++) begin
      seqOp();
      pcE += 4; cntE++;
      stepExp("toBne", pcE, 1'b0, 1'b1, cntE, 1'b1);
    end

    // BNE waits on pending flags, then resolves through the bypass
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 4'h1, 24'h3, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
      stepExp("bneWait", 32'h20, 1'b0, 1'b1, 11, 1'b1);
    end
    drive(2'b10, 4'h1, 24'h3, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
    stepExp("bneBypass", 32'h2C, 1'b1, 1'b1, 12, 1'b0);

    pcE = 32'h2C; cntE = 12;
    for (int i = 0; i < 5; i++) begin
      seqOp();
      pcE += 4; cntE++;
      stepExp("toHalt", pcE, 1'b0, 1'b1, cntE, 1'b0);
    end

    // halt under stall, then released
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 4'h0, 24'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
      stepExp("haltStall", 32'h40, 1'b0, 1'b1, 17, 1'b0);
    end
    drive(2'b11, 4'h0, 24'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    stepExp("halt", 32'h40, 1'b0, 1'b0, 18, 1'b0);
    drive(2'b00, 4'h0, 24'h0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0);
    stepExp("haltedFlags", 32'h40, 1'b0, 1'b0, 18, 1'b1);
    drive(2'b00, 4'h0, 24'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    stepExp("restart", 32'h0, 1'b0, 1'b1, 0, 1'b1);

    // never-condition, LT via bypass, GE on stored flags, AL ignoring pending flags
    drive(2'b10, 4'hF, 24'h4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    stepExp("condNever", 32'h4, 1'b0, 1'b1, 1, 1'b1);
    drive(2'b10, 4'hB, 24'h4, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0);
    stepExp("bltBypass", 32'h14, 1'b1, 1'b1, 2, 1'b0);
    drive(2'b10, 4'hA, 24'h4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    stepExp("bgeNotTaken", 32'h18, 1'b0, 1'b1, 3, 1'b0);
    drive(2'b10, 4'hE, 24'hFFFFF9, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    stepExp("balNeg", 32'hFFFFFFFC, 1'b1, 1'b1, 4, 1'b0);
    seqOp(); stepExp("wrap", 32'h0, 1'b0, 1'b1, 5, 1'b0);
    seqOp(); stepExp("postWrap", 32'h4, 1'b0, 1'b1, 6, 1'b0);

    // asynchronous reset between clock edges
    #3;
    reset = 1'b1;
    #1;
    push("asyncReset", 32'h0, 1'b0, 1'b0, 0, 1'b0);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;
    seqOp(); stepExp("idleHold", 32'h0, 1'b0, 1'b0, 0, 1'b0);

    // saturation of the 4-bit counter instance
    drive(2'b00, 4'h0, 24'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
    stepExp("satStart", 32'h0, 1'b0, 1'b1, 0, 1'b0);
    pcE = 32'h0; cntE = 0;
    for (int i = 0; i < 20; i++) begin
      seqOp();
      pcE += 4; cntE++;
      stepExp("sat", pcE, 1'b0, 1'b1, cntE, 1'b0);
    end
    cmp("sat.pc4", pc4, 32'h50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
